// File: rtl/amem_pkg.sv
// amem_pkg: shared A/M memory state encoding and default geometry.
// Reused by amem_mp and by MMEM/spy logic.
package amem_pkg;

  typedef enum logic {
    AMEM_CLEAR = 1'b0,
    AMEM_RUN   = 1'b1
  } amem_state_e;

  localparam int AMEM_AW    = 10;
  localparam int AMEM_DW    = 32;
  localparam int AMEM_DEPTH = 1 << AMEM_AW;
  localparam int AMEM_NRD   = 2;

endpackage

// File: rtl/amem_rdport.sv
// amem_rdport: one registered read port of amem_mp.
// AMEM_BYPASS_EN selects write-first forwarding on address collision.
module amem_rdport #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rword,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef AMEM_BYPASS_EN
  logic hit;
  assign hit = we && (raddr == waddr);

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = hit ? wdata : rword;
    end
  end
`else
  logic unused;
  assign unused = ^{we, waddr, wdata, raddr};

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rword;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/amem_mp.sv
// amem_mp: 1W/NRD-R scratchpad with post-reset clear sweep.
// Optional macro AMEM_BYPASS_EN: write-first on same-cycle collision.
module amem_mp
  import amem_pkg::*;
#(
  parameter int ADDR_WIDTH = AMEM_AW,
  parameter int DATA_WIDTH = AMEM_DW,
  parameter int NRD        = AMEM_NRD
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic                       we,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [NRD*ADDR_WIDTH-1:0]  raddr,
  input  logic [NRD-1:0]             re,
  output logic [NRD*DATA_WIDTH-1:0]  rdata,
  output logic                       init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  amem_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  logic                  wr_en;
  logic                  run_we;
  logic                  run;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    run_we  = 1'b0;
    wr_addr = waddr;
    wr_data = wdata;
    unique case (state_q)
      AMEM_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q[ADDR_WIDTH-1:0];
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = AMEM_RUN;
        end
      end
      AMEM_RUN: begin
        wr_en  = we;
        run_we = we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= AMEM_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage carries no reset so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      ram_q[wr_addr] <= wr_data;
    end
  end

  assign run       = (state_q == AMEM_RUN);
  assign init_busy = ~run;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

    amem_rdport #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_rd (
      .clk    (clk),
      .reset_n(reset_n),
      .re     (re[g] & run),
      .raddr  (ra),
      .rword  (ram_q[ra]),
      .we     (run_we),
      .waddr  (waddr),
      .wdata  (wdata),
      .rdata  (rdata[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_amem_mp.sv
// tb_amem_mp: random + directed bench for amem_mp against a
// word-array reference model.
module tb_amem_mp;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int NRD   = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              we = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [DW-1:0]     wdata = '0;
  logic [NRD*AW-1:0] raddr = '0;
  logic [NRD-1:0]    re = '0;
  logic [NRD*DW-1:0] rdata;
  logic              init_busy;

  amem_mp #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NRD       (NRD)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .waddr    (waddr),
    .we       (we),
    .wdata    (wdata),
    .raddr    (raddr),
    .re       (re),
    .rdata    (rdata),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] rd_m  [NRD];
  int            left_m = DEPTH;

`ifdef AMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] ra_of(int p);
    return raddr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] rd_of(int p);
    return rdata[p*DW +: DW];
  endfunction

  // Reference: reset wipes, sweep just counts down, run is read-then-write.
  task automatic model_edge();
    if (!reset_n) begin
      foreach (mem_m[a]) mem_m[a] = '0;
      foreach (rd_m[p]) rd_m[p] = '0;
      left_m = DEPTH;
    end else if (left_m > 0) begin
      left_m--;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (re[p]) begin
          if (BYP && we && ra_of(p) == waddr) rd_m[p] = wdata;
          else rd_m[p] = mem_m[ra_of(p)];
        end
      end
      if (we) mem_m[waddr] = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {31'b0, init_busy}, {31'b0, left_m > 0});
    for (int p = 0; p < NRD; p++)
      chk($sformatf("rdata%0d", p), rd_of(p), rd_m[p]);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic rnd_in();
    we    = ($urandom_range(0, 2) == 0);
    waddr = rnd_addr();
    wdata = $urandom;
    re    = NRD'($urandom);
    for (int p = 0; p < NRD; p++) raddr[p*AW +: AW] = rnd_addr();
  endtask

  task automatic set_rd(input logic [NRD-1:0] r,
                        input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1);
    re = r;
    raddr[0 +: AW]  = a0;
    raddr[AW +: AW] = a1;
  endtask

  task automatic set_wr(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    we = w;
    waddr = a;
    wdata = d;
  endtask

  task automatic sweep(input bool_poke);
    int n;
    n = 0;
    do begin
      if (bool_poke && n == 100) set_wr(1'b1, 10'h3FE, 32'hCAFEF00D);
      else rnd_in();
      step();
      n++;
    end while (init_busy && n < 2000);
    chk("sweep_len", DW'(n), DW'(DEPTH));
  endtask

  initial begin
    reset_n = 1'b0;
    set_wr(1'b1, 10'h3FE, 32'h12345678);
    set_rd(2'b11, 10'h3FE, 10'h000);
    repeat (3) step();
    reset_n = 1'b1;
    sweep(1'b1);

    set_wr(1'b0, '0, '0);
    set_rd(2'b11, 10'h000, 10'h1FF);
    step();
    chk("clr_000", rd_of(0), '0);
    chk("clr_1ff", rd_of(1), '0);
    set_rd(2'b11, 10'h3FF, 10'h3FE);
    step();
    chk("clr_3ff", rd_of(0), '0);
    chk("clr_3fe_poke", rd_of(1), '0);

    set_wr(1'b1, 10'h055, 32'hDEADBEEF);
    set_rd(2'b00, '0, '0);
    step();
    set_wr(1'b0, '0, '0);
    set_rd(2'b11, 10'h055, 10'h055);
    step();
    chk("wr_rd_p0", rd_of(0), 32'hDEADBEEF);
    chk("wr_rd_p1", rd_of(1), 32'hDEADBEEF);
    set_rd(2'b00, 10'h001, 10'h002);
    step();
    step();
    chk("hold_p0", rd_of(0), 32'hDEADBEEF);
    chk("hold_p1", rd_of(1), 32'hDEADBEEF);

    set_wr(1'b1, 10'h010, 32'h11111111);
    step();
    set_wr(1'b1, 10'h010, 32'h22222222);
    set_rd(2'b01, 10'h010, 10'h000);
    step();
    chk("collide", rd_of(0), BYP ? 32'h22222222 : 32'h11111111);
    set_wr(1'b0, '0, '0);
    step();
    chk("collide_next", rd_of(0), 32'h22222222);

    set_wr(1'b1, 10'h001, 32'h0000000A);
    set_rd(2'b00, '0, '0);
    step();
    set_wr(1'b1, 10'h002, 32'h0000000B);
    step();
    set_wr(1'b0, '0, '0);
    set_rd(2'b11, 10'h055, 10'h055);
    step();
    set_rd(2'b01, 10'h001, 10'h002);
    step();
    chk("indep_p0", rd_of(0), 32'h0000000A);
    chk("indep_p1", rd_of(1), 32'hDEADBEEF);

    repeat (2000) begin
      rnd_in();
      step();
    end

    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (500) begin
      rnd_in();
      step();
    end
    reset_n = 1'b0;
    set_wr(1'b1, 10'h005, 32'hFFFFFFFF);
    set_rd(2'b11, 10'h005, 10'h006);
    step();
    chk("mid_rst_r0", rd_of(0), '0);
    chk("mid_rst_r1", rd_of(1), '0);
    chk("mid_rst_busy", {31'b0, init_busy}, 32'd1);
    reset_n = 1'b1;
    sweep(1'b0);

    repeat (500) begin
      rnd_in();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amem_mp.md
# amem_mp

Parametrised multi-read-port scratchpad memory; the next generation of the CADR A-memory. One write port and `NRD` independent registered read ports, with a hardware clear sweep after reset so contents are defined without a preload. Sits between the L bus (write data) and the A/M source muxes, and replaces the single-port A memory where the datapath needs simultaneous A-source and debug/spy reads.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, address bits; depth `DEPTH = 1 << ADDR_WIDTH`
- `DATA_WIDTH`, 32, word width
- `NRD`, 2, number of read ports (1..4)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  synchronous reset, active-low
- `waddr`  in  ADDR_WIDTH  write address
- `we`  in  1  write pulse (awp equivalent)
- `wdata`  in  DATA_WIDTH  write data (L bus)
- `raddr`  in  NRD*ADDR_WIDTH  packed read addresses, port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `re`  in  NRD  per-port read enable (arp equivalent)
- `rdata`  out  NRD*DATA_WIDTH  packed registered read data
- `init_busy`  out  1  high while the clear sweep runs; client writes are ignored

## Operation
- States: `CLEAR`, `RUN`. Reset (`reset_n`=0 at an edge) forces `CLEAR`, clear counter=0, all `rdata`=0, `init_busy`=1.
- `CLEAR`: each cycle writes 0 to `ram[cnt]` and increments `cnt`; `we` ignored; `re` ignored (`rdata` holds 0). On the edge that writes `DEPTH-1`, go to `RUN`; `init_busy` drops in the same edge.
- `RUN`: `we`=1 writes `wdata` to `ram[waddr]`. For each port i, `re[i]`=1 loads `rdata[i]` with `ram[raddr_i]`; `re[i]`=0 holds `rdata[i]`.
- Ports are independent; several ports may read the same address in one cycle, all return the same word.
- Counter width `ADDR_WIDTH+1`; no wrap; the sweep ends exactly once per reset.
- Reset asserted mid-sweep or mid-run: restart `CLEAR` from address 0; partially cleared contents are discarded by the fresh sweep.

## Timing
- Read latency 1: address/`re` sampled at edge N, data visible after edge N.
- Write visible to a read issued the following cycle (edge N write, edge N+1 read returns new data).
- Same-cycle read and write to the same address: behaviour set by `AMEM_BYPASS_EN` (below).
- Sweep length: `init_busy` high for exactly `DEPTH` cycles after the first edge with `reset_n`=1 (1024 cycles at default).
- Reset values: `rdata`=0 on all ports, `init_busy`=1.

## Configuration
- `AMEM_BYPASS_EN` defined: write-to-read forwarding. If `we`=1, `re[i]`=1 and `raddr_i`==`waddr` in the same cycle, `rdata[i]` loads `wdata` (write-first). Costs one comparator plus a mux per port.
- Undefined: read-first. The same collision returns the old contents; the new value is visible from the next read. Maps to a plain inferred RAM with no extra logic.

## Structure
- Shared package `amem_pkg`: state encoding (`AMEM_CLEAR`, `AMEM_RUN`) and default width/depth constants reused by MMEM/spy logic.
- One sub-module `amem_rdport`: one read port's registered output and, under `AMEM_BYPASS_EN`, the collision compare/mux. Instantiated `NRD` times by a generate loop. Storage and clear FSM stay in the top.

## Test plan
- Reset sweep: hold `reset_n`=0 for 3 cycles, release → `init_busy` high for exactly 1024 cycles. Then read addr 0x000, 0x1FF, 0x3FF on ports 0/1 → all 0.
- Basic write/read: write 0xDEADBEEF @0x055, next cycle `re`=2'b11 both at 0x055 → both `rdata`=0xDEADBEEF one cycle later. `re`=0 thereafter → value holds.
- Collision: ram[0x010]=0x11111111. Same cycle write 0x22222222 @0x010 and read 0x010 → 0x22222222 with `AMEM_BYPASS_EN`, 0x11111111 without. Next read → 0x22222222 in both builds.
- Writes during sweep: pulse `we` with 0xCAFEF00D @0x3FE while `init_busy`=1 → after sweep, read 0x3FE returns 0.
- Mid-sweep reset: drop `reset_n` at sweep cycle 500 for 1 cycle → `rdata`=0, `init_busy` stays high for a full 1024 cycles after release.
- Independent ports: port0 reads 0x001 (=0xA), port1 reads 0x002 (=0xB) with `re`=2'b01 → `rdata0`=0xA, `rdata1` unchanged from prior value.
